// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette lookup block.
package sprite_pkg;

  localparam int CH_W_DEFAULT = 4;

  typedef struct packed {
    logic [CH_W_DEFAULT-1:0] r;
    logic [CH_W_DEFAULT-1:0] g;
    logic [CH_W_DEFAULT-1:0] b;
  } rgb_t;

  localparam logic [3*CH_W_DEFAULT-1:0] TRANS_KEY_DEFAULT = 12'hF0F;
  localparam rgb_t DEFAULT_BLACK = '{r: '0, g: '0, b: '0};

  typedef enum logic {INIT, RUN} lut_state_t;

endpackage

// File: rtl/sprite_palette_lut_if.sv
// Pixel, palette-write and bank-control signals between the sprite path and the LUT.
interface sprite_palette_lut_if #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 4
);
  logic               pix_valid_in;
  logic [IDX_W-1:0]   pix_index;
  logic               pix_valid_out;
  logic [CH_W-1:0]    red;
  logic [CH_W-1:0]    green;
  logic [CH_W-1:0]    blue;
  logic               transparent;
  logic               wr_en;
  logic               wr_bank;
  logic [IDX_W-1:0]   wr_addr;
  logic [3*CH_W-1:0]  wr_data;
  logic               wr_ready;
  logic               swap_req;
  logic               frame_start;
  logic               active_bank;
  logic               cyc_en;

  modport master (
    output pix_valid_in, pix_index, wr_en, wr_bank, wr_addr, wr_data,
           swap_req, frame_start, cyc_en,
    input  pix_valid_out, red, green, blue, transparent, wr_ready, active_bank
  );

  modport slave (
    input  pix_valid_in, pix_index, wr_en, wr_bank, wr_addr, wr_data,
           swap_req, frame_start, cyc_en,
    output pix_valid_out, red, green, blue, transparent, wr_ready, active_bank
  );
endinterface

// File: rtl/palette_bank_ram.sv
// Simple dual-port palette storage: one synchronous write port, one registered read port.
module palette_bank_ram #(
  parameter int AW = 5,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: storage has no reset so it maps onto RAM macros; the INIT sweep fills it instead.
  // NOTE: non-blocking assignments make a same-address read return the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_palette_lut.sv
// Double-buffered sprite palette LUT with a 2-cycle lookup and transparency-key detect.
// Optional colour cycling over CYC_LO..CYC_HI is built when PALETTE_CYCLE_EN is defined.
module sprite_palette_lut
  import sprite_pkg::*;
#(
  parameter int                IDX_W     = 4,
  parameter int                CH_W      = CH_W_DEFAULT,
  parameter logic [3*CH_W-1:0] TRANS_KEY = TRANS_KEY_DEFAULT,
  parameter int                CYC_LO    = 2,
  parameter int                CYC_HI    = 5
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_palette_lut_if.slave bus
);

  localparam int AW    = IDX_W + 1;
  localparam int RGB_W = 3 * CH_W;

  lut_state_t       state_q, state_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic             active_bank_q, active_bank_d;
  logic             swap_pending_q, swap_pending_d;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [RGB_W-1:0] ram_wdata, ram_rdata;
  logic [IDX_W-1:0] eff_index;
  logic             s1_valid_q, s1_init_q, s2_valid_q;
  logic [RGB_W-1:0] s2_rgb_q, s2_rgb_d;
  logic             s2_trans_q, s2_trans_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_we     = 1'b0;
    ram_waddr  = {bus.wr_bank, bus.wr_addr};
    ram_wdata  = bus.wr_data;
    case (state_q)
      INIT: begin
        // Sweep bank:addr; entry 0 of each bank is black, the rest transparent.
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = (init_cnt_q[IDX_W-1:0] == '0) ? RGB_W'(DEFAULT_BLACK) : TRANS_KEY;
        init_cnt_d = init_cnt_q + AW'(1);
        if (&init_cnt_q) state_d = RUN;
      end
      RUN:     ram_we = bus.wr_en;
      default: state_d = INIT;
    endcase
  end

  // Swap requests collapse into one pending flag, consumed at the next frame start.
  always_comb begin
    swap_pending_d = swap_pending_q | bus.swap_req;
    active_bank_d  = active_bank_q;
    if (bus.frame_start && swap_pending_d) begin
      active_bank_d  = ~active_bank_q;
      swap_pending_d = 1'b0;
    end
  end

`ifdef PALETTE_CYCLE_EN
  localparam int SPAN  = CYC_HI - CYC_LO + 1;
  localparam int OFF_W = (SPAN > 1) ? $clog2(SPAN) : 1;

  logic [OFF_W-1:0] cyc_off_q;
  logic [AW-1:0]    cyc_rel;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc_off_q <= '0;
    end else if (state_q == RUN && bus.frame_start && bus.cyc_en) begin
      cyc_off_q <= (cyc_off_q == OFF_W'(SPAN - 1)) ? '0 : cyc_off_q + OFF_W'(1);
    end
  end

  // Rotate within the cycling range using compare-and-subtract instead of a modulo.
  always_comb begin
    eff_index = bus.pix_index;
    cyc_rel   = '0;
    if (bus.pix_index >= IDX_W'(CYC_LO) && bus.pix_index <= IDX_W'(CYC_HI)) begin
      cyc_rel = AW'(bus.pix_index - IDX_W'(CYC_LO)) + AW'(cyc_off_q);
      if (cyc_rel >= AW'(SPAN)) cyc_rel = cyc_rel - AW'(SPAN);
      eff_index = IDX_W'(CYC_LO) + cyc_rel[IDX_W-1:0];
    end
  end
`else
  logic unused_cyc;
  assign unused_cyc = bus.cyc_en & (CYC_HI > CYC_LO);
  assign eff_index  = bus.pix_index;
`endif

  palette_bank_ram #(.AW(AW), .DW(RGB_W)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({active_bank_q, eff_index}),
    .rdata (ram_rdata)
  );

  // Pixels read while INIT is still sweeping are reported as transparent black.
  always_comb begin
    s2_trans_d = s1_init_q || (ram_rdata == TRANS_KEY);
    s2_rgb_d   = s2_trans_d ? '0 : ram_rdata;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_init_q  <= 1'b1;
      s2_valid_q <= 1'b0;
      s2_rgb_q   <= '0;
      s2_trans_q <= 1'b1;
    end else begin
      s1_valid_q <= bus.pix_valid_in;
      s1_init_q  <= (state_q == INIT);
      s2_valid_q <= s1_valid_q;
      s2_rgb_q   <= s2_rgb_d;
      s2_trans_q <= s2_trans_d;
    end
  end

  assign bus.pix_valid_out = s2_valid_q;
  assign bus.red           = s2_rgb_q[RGB_W-1 -: CH_W];
  assign bus.green         = s2_rgb_q[2*CH_W-1 -: CH_W];
  assign bus.blue          = s2_rgb_q[CH_W-1:0];
  assign bus.transparent   = s2_trans_q;
  assign bus.wr_ready      = (state_q == RUN);
  assign bus.active_bank   = active_bank_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Scoreboard bench for sprite_palette_lut: the driver queues expected pixels, a monitor checks them.
module tb_sprite_palette_lut;
  import sprite_pkg::*;

  typedef struct {
    rgb_t rgb;
    logic trans;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  sprite_palette_lut_if #(.IDX_W(4), .CH_W(4)) bus ();

  sprite_palette_lut #(
    .IDX_W(4), .CH_W(4), .TRANS_KEY(12'hF0F), .CYC_LO(2), .CYC_HI(5)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] rgb, input logic trans);
    exp_t e;
    e.rgb   = rgb_t'(rgb);
    e.trans = trans;
    e.due   = cyc_cnt + 2;
    exp_q.push_back(e);
  endtask

  // One pixel entering at the next edge, with its hand-computed result.
  task automatic drive_pix(input logic [3:0] idx, input logic [11:0] rgb, input logic trans);
    bus.pix_valid_in = 1'b1;
    bus.pix_index    = idx;
    push(rgb, trans);
    tick();
    bus.pix_valid_in = 1'b0;
  endtask

  task automatic wr(input logic bank, input logic [3:0] addr, input logic [11:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_bank = bank;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Counts cycles with wr_ready low; optionally streams index 3 (always transparent black).
  task automatic run_init(input logic hold_pix, output int low_cycles);
    low_cycles = 0;
    while (bus.wr_ready !== 1'b1 && low_cycles < 200) begin
      low_cycles++;
      if (hold_pix) begin
        bus.pix_valid_in = 1'b1;
        bus.pix_index    = 4'd3;
        push(12'h000, 1'b1);
      end
      tick();
    end
    bus.pix_valid_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pix_valid_out"}, bus.pix_valid_out, 0);
    check({tag, " rgb"}, {bus.red, bus.green, bus.blue}, 12'h000);
    check({tag, " transparent"}, bus.transparent, 1);
    check({tag, " wr_ready"}, bus.wr_ready, 0);
    check({tag, " active_bank"}, bus.active_bank, 0);
  endtask

  // Monitor: every valid output pixel is matched against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pix_valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious pix_valid_out: got 1, expected no pixel (cycle %0d)", cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          check("pix rgb", {bus.red, bus.green, bus.blue}, e.rgb);
          check("pix transparent", bus.transparent, e.trans);
          check("pix latency", cyc_cnt, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int low;
    rst_n            = 1'b0;
    bus.pix_valid_in = 1'b0;
    bus.pix_index    = '0;
    bus.wr_en        = 1'b0;
    bus.wr_bank      = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.swap_req     = 1'b0;
    bus.frame_start  = 1'b0;
    bus.cyc_en       = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // INIT sweep with a continuous pixel stream.
    rst_n = 1'b1;
    run_init(1'b1, low);
    check("wr_ready low cycles", low, 32);
    drive_pix(4'd0, 12'h000, 1'b0);
    drive_pix(4'd7, 12'h000, 1'b1);

    // Runtime write to the active bank.
    wr(1'b0, 4'd2, 12'hB85);
    drive_pix(4'd2, 12'hB85, 1'b0);
    drive_pix(4'd2, 12'hB85, 1'b0);

    // Swap: repeated requests collapse; takes effect only after frame_start.
    wr(1'b1, 4'd2, 12'h611);
    bus.swap_req = 1'b1;
    tick();
    tick();
    bus.swap_req = 1'b0;
    drive_pix(4'd2, 12'hB85, 1'b0);
    check("active_bank before frame_start", bus.active_bank, 0);
    bus.frame_start = 1'b1;
    drive_pix(4'd2, 12'hB85, 1'b0);
    bus.frame_start = 1'b0;
    check("active_bank after swap", bus.active_bank, 1);
    drive_pix(4'd2, 12'h611, 1'b0);
    bus.frame_start = 1'b1;
    drive_pix(4'd2, 12'h611, 1'b0);
    bus.frame_start = 1'b0;
    check("active_bank no pending", bus.active_bank, 1);
    drive_pix(4'd2, 12'h611, 1'b0);

    // Same-cycle write and read of one entry returns the old word.
    bus.wr_en   = 1'b1;
    bus.wr_bank = 1'b1;
    bus.wr_addr = 4'd4;
    bus.wr_data = 12'h3C7;
    drive_pix(4'd4, 12'h000, 1'b1);
    bus.wr_en = 1'b0;
    drive_pix(4'd4, 12'h3C7, 1'b0);

    // Last entry of the bank.
    wr(1'b1, 4'd15, 12'h0F0);
    drive_pix(4'd15, 12'h0F0, 1'b0);

`ifdef PALETTE_CYCLE_EN
    wr(1'b1, 4'd2, 12'h111);
    wr(1'b1, 4'd3, 12'h222);
    wr(1'b1, 4'd4, 12'h333);
    wr(1'b1, 4'd5, 12'h444);
    bus.cyc_en = 1'b1;
    drive_pix(4'd5, 12'h444, 1'b0);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    drive_pix(4'd5, 12'h111, 1'b0);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    drive_pix(4'd5, 12'h222, 1'b0);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    drive_pix(4'd5, 12'h333, 1'b0);
    drive_pix(4'd0, 12'h000, 1'b0);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    drive_pix(4'd5, 12'h444, 1'b0);
    drive_pix(4'd2, 12'h111, 1'b0);
    bus.cyc_en = 1'b0;
`endif

    // Reset in the middle of a stream flushes the pipeline and restarts INIT.
    drive_pix(4'd0, 12'h000, 1'b0);
    drive_pix(4'd0, 12'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    // Writes presented during INIT must be ignored.
    bus.wr_en   = 1'b1;
    bus.wr_bank = 1'b0;
    bus.wr_addr = 4'd2;
    bus.wr_data = 12'hABC;
    run_init(1'b0, low);
    bus.wr_en = 1'b0;
    check("wr_ready low cycles after reset", low, 32);
    drive_pix(4'd2, 12'h000, 1'b1);
    drive_pix(4'd0, 12'h000, 1'b0);
    drive_pix(4'd15, 12'h000, 1'b1);

    repeat (4) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
